// File: rtl/smachine_device_ctrl.sv
// S-Machine device controller: LED register, debounced switch with
// sticky rising-edge event and interrupt, behind a req/ack bus port.
//
// Ports:
//   clk, reset      - clock; async active-high reset
//   enable          - global run enable (gates new bus accesses only)
//   req, we         - access request (held until ack), 1 = store
//   addr, wdata     - access address and store data
//   rdata, ack      - load data (zero unless ack), one-cycle completion
//   hit             - combinational address-window match
//   switch          - raw asynchronous switch pin
//   led, irq        - LED drive, switch event interrupt
module smachine_device_ctrl #(
    parameter logic [7:0] DEV_BASE        = 8'hF0,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       hit,
    input  logic       switch,
    output logic       led,
    output logic       irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, EXEC, RESP, HOLD} state_t;

    state_t        state;
    state_t        state_n;
    logic          we_q;
    logic [1:0]    off_q;
    logic [1:0]    wd_q;
    logic [7:0]    rd_cap;
    logic [7:0]    rd_mux;
    logic          led_r;
    logic          ie;
    logic          evt;
    logic          level;
    logic          level_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          exec_wr;
    logic          clr;
    logic          rise;
    logic          unused_wdata;

    // Only the low two data bits carry meaning in any register.
    assign unused_wdata = ^wdata[7:2];

    assign hit     = (addr[7:2] == DEV_BASE[7:2]);
    assign accept  = enable & req & hit;
    assign exec_wr = (state == EXEC) & we_q;
    assign clr     = exec_wr & (off_q == 2'd1) & wd_q[1];
    assign rise    = level & ~level_d;
    assign led     = led_r;
    assign irq     = evt & ie;

    always_comb begin
        rd_mux = 8'h00;
        unique case (off_q)
            2'd0: rd_mux = {7'b0, led_r};
            2'd1: rd_mux = {6'b0, evt, level};
            2'd2: rd_mux = {7'b0, ie};
            2'd3: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = EXEC;
            EXEC: state_n = RESP;
            RESP: state_n = HOLD;
            HOLD: if (!req) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            off_q  <= 2'd0;
            wd_q   <= 2'd0;
            rd_cap <= 8'h00;
            ack    <= 1'b0;
            rdata  <= 8'h00;
            led_r  <= 1'b0;
            ie     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && accept) begin
                we_q  <= we;
                off_q <= addr[1:0];
                wd_q  <= wdata[1:0];
            end
            if (state == EXEC)
                rd_cap <= we_q ? 8'h00 : rd_mux;
            if (exec_wr && off_q == 2'd0)
                led_r <= wd_q[0];
            if (exec_wr && off_q == 2'd2)
                ie <= wd_q[0];
            // Registered response keeps rdata at zero outside the ack cycle.
            ack   <= (state == RESP);
            rdata <= (state == RESP) ? rd_cap : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            evt     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], switch};
            level_d <= level;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                level <= sync_q[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // A new rising edge beats a simultaneous clear.
            if (rise)
                evt <= 1'b1;
            else if (clr)
                evt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smachine_device_ctrl.sv
// Directed self-checking bench for smachine_device_ctrl.
// Drives bus accesses and switch patterns, checks hand-computed values.
module tb_smachine_device_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       hit;
    logic       switch;
    logic       led;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;

    logic [7:0] rd;
    logic       got;

    smachine_device_ctrl #(
        .DEV_BASE(8'hF0),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .req(req),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ack(ack),
        .hit(hit),
        .switch(switch),
        .led(led),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (ack) ack_cnt++;

    task automatic check(input string tag, input logic [7:0] g,
                         input logic [7:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [7:0] a,
                          input logic [7:0] d, input int hold,
                          output logic [7:0] r, output logic g);
        r = 8'h00;
        g = 1'b0;
        req = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack) begin
                r = rdata;
                g = 1'b1;
                break;
            end
        end
        for (int i = 0; i < hold; i++) tick();
        req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        req = 1'b0;
        we = 1'b0;
        addr = 8'h00;
        wdata = 8'h00;
        switch = 1'b0;
        tick();
        tick();
        check("rst_ack", {7'b0, ack}, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_led", {7'b0, led}, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;

        // Disabled: request ignored.
        req = 1'b1;
        we = 1'b1;
        addr = 8'hF0;
        wdata = 8'h01;
        ack_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        check("dis_noack", 8'(ack_cnt), 8'h00);
        check("dis_led", {7'b0, led}, 8'h00);

        // Enable: accept at N, write at N+1, ack after N+2.
        enable = 1'b1;
        tick();
        check("lat_n_ack", {7'b0, ack}, 8'h00);
        check("lat_n_led", {7'b0, led}, 8'h00);
        tick();
        check("lat_n1_led", {7'b0, led}, 8'h01);
        check("lat_n1_ack", {7'b0, ack}, 8'h00);
        tick();
        check("lat_n2_ack", {7'b0, ack}, 8'h01);
        req = 1'b0;
        tick();
        check("ack_pulse", {7'b0, ack}, 8'h00);
        check("ack_once", 8'(ack_cnt), 8'h01);

        access(1'b0, 8'hF0, 8'h00, 0, rd, got);
        check("ld_led_ack", {7'b0, got}, 8'h01);
        check("ld_led", rd, 8'h01);
        access(1'b1, 8'hF0, 8'hFE, 0, rd, got);
        check("st_fe_led", {7'b0, led}, 8'h00);
        access(1'b0, 8'hF0, 8'h00, 0, rd, got);
        check("ld_led0", rd, 8'h00);

        // Chattering switch never settles.
        for (int i = 0; i < 20; i++) begin
            switch = ~switch;
            tick();
        end
        switch = 1'b0;
        access(1'b0, 8'hF1, 8'h00, 0, rd, got);
        check("glitch_stat", rd, 8'h00);

        // Stable high: level then event.
        switch = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        access(1'b0, 8'hF1, 8'h00, 0, rd, got);
        check("deb_stat", rd, 8'h03);
        check("irq_noie", {7'b0, irq}, 8'h00);
        access(1'b1, 8'hF2, 8'h01, 0, rd, got);
        check("irq_ie", {7'b0, irq}, 8'h01);
        access(1'b0, 8'hF2, 8'h00, 0, rd, got);
        check("ld_ctrl", rd, 8'h01);

        // W1C.
        access(1'b1, 8'hF1, 8'h02, 0, rd, got);
        check("w1c_irq", {7'b0, irq}, 8'h00);
        access(1'b0, 8'hF1, 8'h00, 0, rd, got);
        check("w1c_stat", rd, 8'h01);

        // Clear and new rising edge on the same edge.
        switch = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        access(1'b0, 8'hF1, 8'h00, 0, rd, got);
        check("fall_stat", rd, 8'h00);
        switch = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        access(1'b1, 8'hF1, 8'h02, 0, rd, got);
        check("coll_irq", {7'b0, irq}, 8'h01);
        access(1'b0, 8'hF1, 8'h00, 0, rd, got);
        check("coll_stat", rd, 8'h03);

        // Held request: one access only.
        ack_cnt = 0;
        access(1'b1, 8'hF0, 8'h01, 6, rd, got);
        check("hold_ack", 8'(ack_cnt), 8'h01);
        check("hold_led", {7'b0, led}, 8'h01);

        // Outside the window.
        addr = 8'h10;
        #1;
        check("miss_hit", {7'b0, hit}, 8'h00);
        addr = 8'hF3;
        #1;
        check("win_hit", {7'b0, hit}, 8'h01);
        ack_cnt = 0;
        access(1'b1, 8'h10, 8'h00, 0, rd, got);
        check("miss_noack", 8'(ack_cnt), 8'h00);
        check("miss_led", {7'b0, led}, 8'h01);

        // Reserved offset.
        access(1'b1, 8'hF3, 8'hFF, 0, rd, got);
        check("rsv_st_ack", {7'b0, got}, 8'h01);
        access(1'b0, 8'hF3, 8'h00, 0, rd, got);
        check("rsv_ld_ack", {7'b0, got}, 8'h01);
        check("rsv_ld", rd, 8'h00);

        // Reset during EXEC of a store.
        access(1'b1, 8'hF0, 8'h00, 0, rd, got);
        req = 1'b1;
        we = 1'b1;
        addr = 8'hF0;
        wdata = 8'h01;
        ack_cnt = 0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        req = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        check("mid_noack", 8'(ack_cnt), 8'h00);
        check("mid_led", {7'b0, led}, 8'h00);
        check("mid_irq", {7'b0, irq}, 8'h00);
        access(1'b1, 8'hF0, 8'h01, 0, rd, got);
        check("post_ack", {7'b0, got}, 8'h01);
        check("post_led", {7'b0, led}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
